// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU frame packer:
//   - trailer magic byte and trailer field offsets
//   - ingress FSM state enum
//   - helper functions: 32->16 checksum fold and trailer word assembly
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam logic [7:0] ALU_TRAILER_MAGIC = 8'hA5;

  // Trailer layout: {magic[31:24], 2'b00, err[21], len[20:16], csum[15:0]}
  localparam int ALU_MAGIC_LSB = 24;
  localparam int ALU_ERR_BIT   = 21;
  localparam int ALU_LEN_LSB   = 16;
  localparam int ALU_LEN_W     = 5;
  localparam int ALU_CSUM_LSB  = 0;
  localparam int ALU_CSUM_W    = 16;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } alu_state_t;

  // Checksum contribution of one payload word.
  function automatic logic [ALU_CSUM_W-1:0] alu_fold(input logic [31:0] word);
    return word[31:16] ^ word[15:0];
  endfunction

  function automatic logic [31:0] alu_trailer(input logic                  err,
                                              input logic [ALU_LEN_W-1:0]  len,
                                              input logic [ALU_CSUM_W-1:0] csum);
    logic [31:0] t;
    t                               = '0;
    t[ALU_MAGIC_LSB +: 8]           = ALU_TRAILER_MAGIC;
    t[ALU_ERR_BIT]                  = err;
    t[ALU_LEN_LSB +: ALU_LEN_W]     = len;
    t[ALU_CSUM_LSB +: ALU_CSUM_W]   = csum;
    return t;
  endfunction

endpackage

// File: rtl/alu_sync_fifo.sv
// ---------------------------------------------------------------------------
// alu_sync_fifo
// Single-clock FIFO with an explicit occupancy counter.
//   clk, rst   : clock, synchronous active-high reset (pointers/count only)
//   i_push     : write request; ignored when full
//   i_data     : write data
//   i_pop      : read request; ignored when empty
//   o_data     : head entry (zero while empty)
//   o_full     : count == DEPTH
//   o_empty    : count == 0
//   o_count    : occupancy, log2(DEPTH)+1 bits
// A pop in the same cycle never makes room for a push (no pass-through).
// ---------------------------------------------------------------------------
module alu_sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 64,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_wr;
  logic             w_rd;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign w_wr    = i_push && !o_full;
  assign w_rd    = i_pop && !o_empty;

  // Gate the head so the output reads zero after reset and while empty.
  assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/alu_frame_packer.sv
// ---------------------------------------------------------------------------
// alu_frame_packer
// Packs contiguous framer bursts into packets: payload words followed by one
// trailer {A5, 2'b00, err, len[4:0], csum[15:0]}, buffered in a FIFO and
// presented on a valid/ready egress with sop/eop markers.
//   clk, rst    : clock, synchronous active-high reset
//   frame       : high for each payload word of a frame
//   frame_data  : payload word
//   pkt_valid   : FIFO head presentable
//   pkt_data    : FIFO head word
//   pkt_sop     : head is first word of a packet
//   pkt_eop     : head is a trailer
//   pkt_ready   : downstream accepts head this cycle
//   pkt_bp      : registered backpressure (occupancy >= BP_LEVEL)
//   pkt_ovf     : sticky overflow, set when any word is dropped
// ---------------------------------------------------------------------------
module alu_frame_packer
  import alu_pkg::*;
#(
  parameter int DEPTH    = 64,
  parameter int BP_LEVEL = DEPTH - 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame,
  input  logic [31:0] frame_data,
  output logic        pkt_valid,
  output logic [31:0] pkt_data,
  output logic        pkt_sop,
  output logic        pkt_eop,
  input  logic        pkt_ready,
  output logic        pkt_bp,
  output logic        pkt_ovf
);

  localparam int CW = $clog2(DEPTH) + 1;

  alu_state_t             r_state;
  alu_state_t             w_state_nxt;
  logic [ALU_LEN_W-1:0]   r_len;
  logic [ALU_CSUM_W-1:0]  r_csum;
  logic                   r_err;
  logic                   r_sop_pend;
  logic                   r_bp;
  logic                   r_ovf;

  logic                   w_push;
  logic [32:0]            w_push_data;
  logic                   w_push_ok;
  logic                   w_pop;
  logic [32:0]            w_head;
  logic                   w_full;
  logic                   w_empty;
  logic [CW-1:0]          w_count;
  logic [CW-1:0]          w_count_nxt;

  alu_sync_fifo #(
    .WIDTH (33),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign pkt_valid   = !w_empty;
  assign pkt_data    = w_head[31:0];
  assign pkt_eop     = w_head[32];
  assign pkt_sop     = r_sop_pend && pkt_valid;
  assign pkt_bp      = r_bp;
  assign pkt_ovf     = r_ovf;

  assign w_pop       = pkt_valid && pkt_ready;
  assign w_push_ok   = w_push && !w_full;
  assign w_count_nxt = w_count + CW'(w_push_ok) - CW'(w_pop);

  // Ingress FSM: next state and FIFO write request.
  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_push_data = '0;
    case (r_state)
      IDLE: begin
        if (frame) begin
          w_push      = 1'b1;
          w_push_data = {1'b0, frame_data};
          w_state_nxt = COLLECT;
        end
      end
      COLLECT: begin
        w_push = 1'b1;
        if (frame) begin
          w_push_data = {1'b0, frame_data};
        end else begin
          // First low cycle closes the frame with its trailer.
          w_push_data = {1'b1, alu_trailer(r_err, r_len, r_csum)};
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Accumulators: dropped payload words still count toward len/csum so the
  // trailer describes what the framer sent, with err flagging the loss.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_len  <= '0;
      r_csum <= '0;
      r_err  <= 1'b0;
    end else if (frame) begin
      if (r_state == IDLE) begin
        r_len  <= ALU_LEN_W'(1);
        r_csum <= alu_fold(frame_data);
        r_err  <= !w_push_ok;
      end else begin
        r_len  <= r_len + 1'b1;
        r_csum <= r_csum ^ alu_fold(frame_data);
        r_err  <= r_err | !w_push_ok;
      end
    end
  end

  // Egress packet tracking and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sop_pend <= 1'b1;
      r_bp       <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      if (w_pop) r_sop_pend <= w_head[32];
      r_bp <= (int'(w_count_nxt) >= BP_LEVEL);
      if (w_push && w_full) r_ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_frame_packer.sv
module tb_alu_frame_packer;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame;
  logic [31:0] frame_data;
  logic        pkt_valid;
  logic [31:0] pkt_data;
  logic        pkt_sop;
  logic        pkt_eop;
  logic        pkt_ready;
  logic        pkt_bp;
  logic        pkt_ovf;

  always #5 clk = ~clk;

  alu_frame_packer #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .frame      (frame),
    .frame_data (frame_data),
    .pkt_valid  (pkt_valid),
    .pkt_data   (pkt_data),
    .pkt_sop    (pkt_sop),
    .pkt_eop    (pkt_eop),
    .pkt_ready  (pkt_ready),
    .pkt_bp     (pkt_bp),
    .pkt_ovf    (pkt_ovf)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  logic [32:0] exp_q[$];

  // Reference packer/occupancy model
  bit          m_coll = 0;
  logic [4:0]  m_len  = '0;
  logic [15:0] m_csum = '0;
  bit          m_err  = 0;
  int          m_cnt  = 0;

  // Monitor state
  bit          mon_sop = 1;
  bit          mon_stall = 0;
  logic [33:0] mon_snap;
  logic [32:0] mon_hd;
  logic [31:0] last_eop_data = '0;
  logic [31:0] last_data = '0;
  logic        last_eop = 1'b0;
  int          n_eop = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] fold(input logic [31:0] w);
    return w[31:16] ^ w[15:0];
  endfunction

  // Drive one cycle of inputs and queue whatever the spec says gets stored.
  task automatic step(input bit f, input logic [31:0] d, input bit rdy);
    bit          pop;
    bit          wr;
    bit          ok;
    logic [32:0] w;
    frame      = f;
    frame_data = d;
    pkt_ready  = rdy;
    pop = (m_cnt != 0) && rdy;
    wr  = 0;
    w   = '0;
    if (!m_coll) begin
      if (f) begin
        wr = 1; w = {1'b0, d};
        m_len = 5'd1; m_csum = fold(d); m_err = 0; m_coll = 1;
      end
    end else if (f) begin
      wr = 1; w = {1'b0, d};
      m_len = m_len + 5'd1; m_csum = m_csum ^ fold(d);
    end else begin
      wr = 1; w = {1'b1, 8'hA5, 2'b00, m_err, m_len, m_csum};
      m_coll = 0;
    end
    ok = wr && (m_cnt < DEPTH);
    if (ok) exp_q.push_back(w);
    else if (wr && !w[32]) m_err = 1;
    m_cnt = m_cnt + (ok ? 1 : 0) - (pop ? 1 : 0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input bit f, input logic [31:0] d);
    rst = 1'b1; frame = f; frame_data = d; pkt_ready = 1'b0;
    exp_q.delete();
    m_coll = 0; m_cnt = 0; m_len = '0; m_csum = '0; m_err = 0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic drain(input int maxc);
    int c;
    c = 0;
    while ((exp_q.size() != 0 || pkt_valid) && c < maxc) begin
      step(0, 32'h0, 1);
      c++;
    end
    chk("drain_done", {63'h0, (exp_q.size() == 0 && !pkt_valid)}, 64'h1);
  endtask

  // Scoreboard monitor: sampled on the falling edge, i.e. just before the
  // rising edge at which a transfer would happen.
  always @(negedge clk) begin
    if (rst) begin
      mon_sop   = 1;
      mon_stall = 0;
    end else begin
      if (mon_stall && pkt_valid)
        chk("hold_stable", {30'h0, pkt_sop, pkt_eop, pkt_data}, {30'h0, mon_snap});
      if (pkt_valid && pkt_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_word", {31'h0, pkt_eop, pkt_data}, 64'h0);
          mon_sop = pkt_eop;
        end else begin
          mon_hd = exp_q.pop_front();
          chk("egress_word", {31'h0, pkt_eop, pkt_data}, {31'h0, mon_hd});
          chk("egress_sop", {63'h0, pkt_sop}, {63'h0, mon_sop});
          mon_sop = mon_hd[32];
        end
        last_data = pkt_data;
        last_eop  = pkt_eop;
        if (pkt_eop) begin
          last_eop_data = pkt_data;
          n_eop++;
        end
      end
      mon_stall = pkt_valid && !pkt_ready;
      mon_snap  = {pkt_sop, pkt_eop, pkt_data};
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    logic [31:0] d;
    rst = 1'b1; frame = 1'b0; frame_data = '0; pkt_ready = 1'b0;
    do_reset(0, 32'h0);
    chk("reset_outputs", {25'h0, pkt_valid, pkt_sop, pkt_eop, pkt_bp, pkt_ovf, pkt_data}, 64'h0);

    // Single 3-word frame, always ready
    e0 = n_eop;
    step(1, 32'h11112222, 1);
    chk("t1_latency", {31'h0, pkt_valid, pkt_sop, pkt_data}, {31'h0, 1'b1, 1'b1, 32'h11112222});
    step(1, 32'h33334444, 1);
    step(1, 32'h55556666, 1);
    chk("t1_last_payload", {31'h0, pkt_valid, pkt_eop, pkt_data}, {31'h0, 1'b1, 1'b0, 32'h55556666});
    step(0, 32'h0, 1);
    chk("t1_trailer_head", {31'h0, pkt_valid, pkt_eop, pkt_data}, {31'h0, 1'b1, 1'b1, 32'hA5037777});
    drain(20);
    chk("t1_trailer", {32'h0, last_eop_data}, {32'h0, 32'hA5037777});
    chk("t1_eop_count", 64'(n_eop - e0), 64'd1);

    // Back-to-back 31-word frames, ready toggling
    e0 = n_eop;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 31; i++) begin
        d = {16'(i * 7 + p * 100 + 1), 16'(i * 13 + 5)};
        step(1, d, i[0]);
      end
      step(0, 32'h0, 1);
    end
    for (int i = 0; i < 200 && (exp_q.size() != 0 || pkt_valid); i++) step(0, 32'h0, i[0]);
    drain(40);
    chk("t2_eop_count", 64'(n_eop - e0), 64'd2);
    chk("t2_len_field", {59'h0, last_eop_data[20:16]}, 64'd31);

    // Simultaneous push and pop at occupancy 1
    for (int i = 0; i < 20; i++) begin
      d = 32'hC0DE0000 + 32'(i);
      step(1, d, 1);
      chk("pp_head", {31'h0, pkt_valid, pkt_bp, pkt_data}, {31'h0, 1'b1, 1'b0, d});
    end
    step(0, 32'h0, 1);
    drain(10);

    // Fill with two full frames while stalled; third frame dropped
    for (int i = 0; i < 31; i++) step(1, 32'hAA000000 + 32'(i), 0);
    chk("t3_bp_at31", {63'h0, pkt_bp}, 64'h0);
    step(0, 32'h0, 0);
    chk("t3_bp_at32", {63'h0, pkt_bp}, 64'h1);
    for (int i = 0; i < 31; i++) step(1, 32'hBB000000 + 32'(i), 0);
    step(0, 32'h0, 0);
    chk("t3_ovf_before", {63'h0, pkt_ovf}, 64'h0);
    for (int i = 0; i < 5; i++) step(1, 32'hCC000000 + 32'(i), 0);
    step(0, 32'h0, 0);
    chk("t3_ovf_after", {63'h0, pkt_ovf}, 64'h1);
    chk("t3_head", {31'h0, pkt_valid, pkt_sop, pkt_data}, {31'h0, 1'b1, 1'b1, 32'hAA000000});
    drain(100);
    chk("t3_last_trailer", {48'h0, last_eop_data[31:16]}, 64'hA51F);
    chk("t3_last_eop", {63'h0, last_eop}, 64'h1);

    // Overflow mid-frame from 63 entries
    do_reset(0, 32'h0);
    chk("t4_ovf_cleared", {63'h0, pkt_ovf}, 64'h0);
    for (int i = 0; i < 30; i++) step(1, 32'hD0000000 + 32'(i), 0);
    step(0, 32'h0, 0);
    for (int i = 0; i < 31; i++) step(1, 32'hD1000000 + 32'(i), 0);
    step(0, 32'h0, 0);
    step(1, 32'hE0E0E0E0, 0);
    chk("t4_ovf_word1", {63'h0, pkt_ovf}, 64'h0);
    step(1, 32'hE1E1E1E1, 0);
    chk("t4_ovf_word2", {63'h0, pkt_ovf}, 64'h1);
    step(0, 32'h0, 0);
    drain(100);
    chk("t4_last_stored", {31'h0, last_eop, last_data}, {31'h0, 1'b0, 32'hE0E0E0E0});
    step(1, 32'h12340001, 1);
    step(1, 32'h12340002, 1);
    step(0, 32'h0, 1);
    drain(10);
    chk("t4_ovf_sticky", {63'h0, pkt_ovf}, 64'h1);

    // Reset on the 5th word of a 10-word frame
    for (int i = 1; i <= 4; i++) step(1, 32'hF0000000 + 32'(i), 0);
    do_reset(1, 32'hF0000005);
    chk("t5_reset_outputs", {25'h0, pkt_valid, pkt_sop, pkt_eop, pkt_bp, pkt_ovf, pkt_data}, 64'h0);
    e0 = n_eop;
    step(1, 32'hF0000006, 1);
    chk("t5_new_start", {31'h0, pkt_valid, pkt_sop, pkt_data}, {31'h0, 1'b1, 1'b1, 32'hF0000006});
    for (int i = 7; i <= 10; i++) step(1, 32'hF0000000 + 32'(i), 1);
    step(0, 32'h0, 1);
    drain(10);
    chk("t5_eop_count", 64'(n_eop - e0), 64'd1);
    chk("t5_trailer_hdr", {48'h0, last_eop_data[31:16]}, 64'hA505);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
